rf_writeback_queue: RTL and testbench



---
 rtl/rf_writeback_queue_pkg.sv | 23 ++
 rtl/rf_writeback_queue_wb_fifo.sv | 100 ++++++++++
 rtl/rf_writeback_queue.sv | 126 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// rf_writeback_queue_pkg
// Shared constants and the writeback entry type used by the register-file
// writeback queue and its LSU FIFO.
//   WB_ADDR_W   : register address width
//   WB_DATA_W   : register data width
//   WB_NUM_REGS : number of architectural registers (2**WB_ADDR_W)
//   wb_entry_t  : {live, addr, data}. live=0 marks an entry superseded by a
//                 younger ALU write; it still occupies its slot in order.
// -----------------------------------------------------------------------------
package rf_writeback_queue_pkg;

  localparam int WB_ADDR_W   = 5;
  localparam int WB_DATA_W   = 32;
  localparam int WB_NUM_REGS = 1 << WB_ADDR_W;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Circular buffer of LSU writeback entries with a kill-by-address port.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_push, i_push_*    : enqueue {live=1, addr, data}; ignored when full
//   i_pop               : dequeue the head; ignored when empty
//   i_kill, i_kill_addr : clear live on every valid entry targeting the address
//   o_head              : entry at the head pointer
//   o_count, o_full     : occupancy
//   o_live, o_addr      : per-slot (valid && live) and destination address
// -----------------------------------------------------------------------------
module wb_fifo
  import rf_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_push,
  input  logic [WB_ADDR_W-1:0]              i_push_addr,
  input  logic [WB_DATA_W-1:0]              i_push_data,
  input  logic                              i_pop,
  input  logic                              i_kill,
  input  logic [WB_ADDR_W-1:0]              i_kill_addr,
  output wb_entry_t                         o_head,
  output logic [CNT_W-1:0]                  o_count,
  output logic                              o_full,
  output logic [DEPTH-1:0]                  o_live,
  output logic [DEPTH-1:0][WB_ADDR_W-1:0]   o_addr
);

  wb_entry_t            r_mem [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  always_comb begin
    o_live = '0;
    o_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_live[i] = r_valid[i] && r_mem[i].live;
      o_addr[i] = r_mem[i].addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Kill only touches entries already stored; the slot being pushed this
      // cycle is invalid here and its write below carries live=1.
      if (i_kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && (r_mem[i].addr == i_kill_addr)) begin
            r_mem[i].live <= 1'b0;
          end
        end
      end

      // Push only when not full and pop only when not empty, so head and
      // tail never name the same slot in a cycle where both act.
      if (w_push) begin
        r_mem[r_tail]   <= '{live: 1'b1, addr: i_push_addr, data: i_push_data};
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end

      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// -----------------------------------------------------------------------------
// rf_writeback_queue
// Serialises ALU and LSU writebacks onto the single register-file write port.
// ALU writes always win and are never stalled; LSU writes are buffered in a
// small FIFO and drained in idle ALU slots. An ALU write supersedes any queued
// LSU write to the same register.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   alu_valid/alu_waddr/alu_wdata   : ALU writeback, no backpressure
//   lsu_valid/lsu_ready/lsu_waddr/lsu_wdata : LSU writeback handshake
//   reg_wr/waddr/wdata              : registered register-file write port
//   busy                            : registers with a live queued writeback
//   count                           : FIFO occupancy
// -----------------------------------------------------------------------------
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DATA_W   = WB_DATA_W,
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_waddr,
  input  logic [DATA_W-1:0]        alu_wdata,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_W-1:0]        lsu_waddr,
  input  logic [DATA_W-1:0]        lsu_wdata,
  output logic                     reg_wr,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  output logic [NUM_REGS-1:0]      busy,
  output logic [$clog2(DEPTH):0]   count
);

  // The entry type is fixed by the package, so the widths must agree with it.
  if (ADDR_W != WB_ADDR_W || DATA_W != WB_DATA_W || NUM_REGS != (1 << ADDR_W)
      || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("rf_writeback_queue: unsupported parameter combination");
  end

  logic                            w_full;
  logic                            w_accept;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_kill;
  wb_entry_t                       w_head;
  logic [DEPTH-1:0]                w_live;
  logic [DEPTH-1:0][ADDR_W-1:0]    w_addr;
  logic [NUM_REGS-1:0]             w_busy;

  logic                            r_reg_wr;
  logic [ADDR_W-1:0]               r_waddr;
  logic [DATA_W-1:0]               r_wdata;

  // No pass-through when full: a pop this cycle does not free a slot until
  // the next edge.
  assign lsu_ready = !reset && !w_full;
  assign w_accept  = lsu_valid && lsu_ready;
  // Writes to x0 complete the handshake but are never stored.
  assign w_push    = w_accept && (lsu_waddr != '0);
  assign w_pop     = !alu_valid && (count != '0);
  assign w_kill    = alu_valid && (alu_waddr != '0);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_push      (w_push),
    .i_push_addr (lsu_waddr),
    .i_push_data (lsu_wdata),
    .i_pop       (w_pop),
    .i_kill      (w_kill),
    .i_kill_addr (alu_waddr),
    .o_head      (w_head),
    .o_count     (count),
    .o_full      (w_full),
    .o_live      (w_live),
    .o_addr      (w_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg_wr <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (alu_valid) begin
      r_reg_wr <= (alu_waddr != '0);
      if (alu_waddr != '0) begin
        r_waddr <= alu_waddr;
        r_wdata <= alu_wdata;
      end
    end else if (count != '0) begin
      // A killed head still takes its slot, but with the write suppressed;
      // address/data hold so superseded load data never reaches the port.
      r_reg_wr <= w_head.live;
      if (w_head.live) begin
        r_waddr <= w_head.addr;
        r_wdata <= w_head.data;
      end
    end else begin
      r_reg_wr <= 1'b0;
    end
  end

  assign reg_wr = r_reg_wr;
  assign waddr  = r_waddr;
  assign wdata  = r_wdata;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i]) begin
        w_busy[w_addr[i]] = 1'b1;
      end
    end
    w_busy[0] = 1'b0;
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } m_ent_t;

  m_ent_t      q[$];
  logic        e_wr    = 1'b0;
  logic [4:0]  e_waddr = '0;
  logic [31:0] e_wdata = '0;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_waddr (lsu_waddr),
    .lsu_wdata (lsu_wdata),
    .reg_wr    (reg_wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    foreach (q[i]) if (q[i].live && q[i].addr != 5'd0) b[q[i].addr] = 1'b1;
    return b;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs against the
  // model before the edge, advance the model, check the write port after.
  task automatic cyc(input logic rs, input logic av, input logic [4:0] aa,
                     input logic [31:0] ad, input logic lv, input logic [4:0] la,
                     input logic [31:0] ld);
    logic   rdy;
    m_ent_t h;
    @(negedge clock);
    reset = rs; alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    #1;
    rdy = !rs && (q.size() < DEPTH);
    chk("lsu_ready", 64'(lsu_ready), 64'(rdy));
    chk("count", 64'(count), 64'(q.size()));
    chk("busy", 64'(busy), 64'(m_busy()));
    @(posedge clock);
    if (rs) begin
      q.delete();
      e_wr = 1'b0; e_waddr = '0; e_wdata = '0;
    end else begin
      if (av) begin
        e_wr = (aa != 5'd0);
        if (e_wr) begin e_waddr = aa; e_wdata = ad; end
        if (aa != 5'd0) foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        e_wr = h.live;
        if (h.live) begin e_waddr = h.addr; e_wdata = h.data; end
      end else begin
        e_wr = 1'b0;
      end
      if (lv && rdy && la != 5'd0) q.push_back('{1'b1, la, ld});
    end
    #1;
    chk("reg_wr", 64'(reg_wr), 64'(e_wr));
    if (e_wr || rs) begin
      chk("waddr", 64'(waddr), 64'(e_waddr));
      chk("wdata", 64'(wdata), 64'(e_wdata));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;

    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);

    // single LSU write r5 = 0x1234
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    chk("s1_count", 64'(count), 64'd1);
    chk("s1_busy5", 64'(busy[5]), 64'd1);
    idle(1);
    chk("s1_wr", 64'(reg_wr), 64'd1);
    chk("s1_waddr", 64'(waddr), 64'd5);
    chk("s1_wdata", 64'(wdata), 64'h1234);
    chk("s1_count0", 64'(count), 64'd0);
    chk("s1_busy0", 64'(busy), 64'd0);

    // four pushes under continuous ALU traffic, then ordered drain
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 5'(i + 1), 32'(i + 100), 1'b1, 5'(i + 10), 32'(i + 32'hB000));
    chk("s2_full_ready", 64'(lsu_ready), 64'd0);
    cyc(1'b0, 1'b1, 5'd1, 32'd7, 1'b1, 5'd14, 32'hDEAD);
    chk("s2_held_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("s2_order_addr", 64'(waddr), 64'(i + 10));
      chk("s2_order_data", 64'(wdata), 64'(i + 32'hB000));
    end

    // ALU write supersedes queued LSU write to the same register
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA);
    cyc(1'b0, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 32'd0);
    chk("s3_wdata", 64'(wdata), 64'h5555);
    chk("s3_busy7", 64'(busy[7]), 64'd0);
    idle(1);
    chk("s3_killed_pop", 64'(reg_wr), 64'd0);
    idle(1);

    // writes to x0
    cyc(1'b0, 1'b1, 5'd0, 32'h1111, 1'b1, 5'd0, 32'h2222);
    chk("s4_count", 64'(count), 64'd0);
    chk("s4_wr", 64'(reg_wr), 64'd0);
    idle(1);

    // full with push offered while popping: 4, 3, 4
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 5'(i + 20), 32'(i + 32'hC000));
    chk("s5_count4", 64'(count), 64'd4);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 32'hC004);
    chk("s5_count3", 64'(count), 64'd3);
    cyc(1'b0, 1'b1, 5'd2, 32'd2, 1'b1, 5'd24, 32'hC004);
    chk("s5_count4b", 64'(count), 64'd4);
    idle(5);

    // reset with three entries queued
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 5'd1, 32'd3, 1'b1, 5'(i + 8), 32'(i + 32'hE000));
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hE00F);
    chk("s6_count", 64'(count), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_wr", 64'(reg_wr), 64'd0);
    idle(3);

    // randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom(),
          ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom());
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
